// File: rtl/rf_pkg.sv
// Shared register-file types: widths, address/data types and the write-port bundle.
package rf_pkg;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 2 ** AW;

    typedef logic [AW-1:0]   rf_addr_t;
    typedef logic [XLEN-1:0] rf_data_t;

    typedef struct packed {
        logic     en;
        rf_addr_t wa;
        rf_data_t wd;
    } rf_wr_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps.
// On advance, the pointer moves to the slot just past the grantee.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_d, ptr_q;
    logic [PW-1:0] grant_idx;
    logic          found;
    int            idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin shares the single write port
// among requesters, registers the port, and keeps the RAW busy scoreboard.
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = rf_pkg::XLEN,
    parameter int AW   = rf_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_wa,
    input  logic [NREQ*XLEN-1:0] req_wd,
    input  logic                 busy_set,
    input  logic [AW-1:0]        busy_addr,
    input  logic                 flush,
    output logic                 rf_en,
    output logic [AW-1:0]        rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    output logic [2**AW-1:0]     busy
);
    import rf_pkg::rf_wr_t;

    localparam int NR = 2 ** AW;

    logic [NREQ-1:0] grant;
    logic            transfer;
    logic [AW-1:0]   sel_wa;
    logic [XLEN-1:0] sel_wd;
    rf_wr_t          wr_d, wr_q;
    logic [NR-1:0]   busy_d, busy_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (transfer),
        .grant   (grant)
    );

    assign req_ready = grant;
    assign transfer  = |(req_valid & grant);

    always_comb begin
        sel_wa = '0;
        sel_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_wa = req_wa[i*AW +: AW];
                sel_wd = req_wd[i*XLEN +: XLEN];
            end
        end
    end

    // x0 writes are accepted but never occupy the port; wa/wd hold otherwise.
    always_comb begin
        wr_d    = wr_q;
        wr_d.en = 1'b0;
        if (transfer && (sel_wa != '0)) begin
            wr_d.en = 1'b1;
            wr_d.wa = sel_wa;
            wr_d.wd = sel_wd;
        end
    end

    // Order encodes priority: retire clear, then new reservation, then flush.
    always_comb begin
        busy_d = busy_q;
        if (transfer) busy_d[sel_wa] = 1'b0;
        if (busy_set) busy_d[busy_addr] = 1'b1;
        if (flush)    busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            busy_q <= '0;
        end else begin
            wr_q   <= wr_d;
            busy_q <= busy_d;
        end
    end

    assign rf_en = wr_q.en;
    assign rf_wa = wr_q.wa;
    assign rf_wd = wr_q.wd;
    assign busy  = busy_q;
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback requesters: ALU (0), load unit (1), debug/CSR (2).
- Round-robin grant with a valid/ready handshake per requester.
- Registered write-port outputs drive the register file's en/wa/wd directly.
- Maintains a per-register busy scoreboard, which issue logic uses for RAW hazard stalls.

Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- XLEN, 32, data width
- AW, 5, register address width (2**AW registers)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  requester i has a write pending
- req_ready  out  NREQ  requester i accepted this cycle (one-hot or zero)
- req_wa  in  NREQ*AW  destination address, requester i at bits [i*AW +: AW]
- req_wd  in  NREQ*XLEN  write data, requester i at bits [i*XLEN +: XLEN]
- busy_set  in  1  issue stage reserves a destination register
- busy_addr  in  AW  register being reserved
- flush  in  1  clears all busy bits (pipeline flush)
- rf_en  out  1  write enable to register file
- rf_wa  out  AW  write address to register file
- rf_wd  out  XLEN  write data to register file
- busy  out  2**AW  scoreboard, bit r = register r has an outstanding producer

Behaviour:
- Reset (async assert, sync release):
  - rf_en=0, rf_wa=0, rf_wd=0, busy=0, rr_ptr=0.
  - A write accepted in the cycle of reset assertion is discarded.
- Arbitration is combinational from req_valid and rr_ptr.
  - Search starts at index rr_ptr and proceeds rr_ptr+1, ... wrapping mod NREQ.
  - The first valid index is granted.
  - req_ready[g]=1 only for grantee g; all others 0; req_ready=0 when no valid.
  - req_ready may depend on req_valid.
  - Requesters hold valid/wa/wd stable until ready.
- Transfer occurs when req_valid[g] & req_ready[g]; at most one per cycle.
- rr_ptr:
  - On transfer, next rr_ptr = (g+1) mod NREQ.
  - With no transfer, rr_ptr holds.
  - A continuously requesting source waits at most NREQ-1 cycles.
- Write port (registered, latency 1):
  - The cycle after a transfer, rf_en=1, rf_wa=req_wa[g], rf_wd=req_wd[g].
  - Otherwise rf_en=0; rf_wa/rf_wd hold their last values.
  - Transfer with wa==0: accepted (ready=1, pointer advances) but rf_en stays 0 next cycle. Writes to x0 never consume a port slot.
- Throughput: one write per cycle, back-to-back.
- Scoreboard (busy register):
  - Clear: a transfer to address a≠0 clears busy[a] at the next edge, the same edge rf_en goes high.
  - Set: busy_set with busy_addr=a≠0 sets busy[a] at the next edge.
  - Simultaneous set and clear of the same a: set wins (new producer outranks retiring one).
  - busy[0] is constant 0; busy_set to address 0 is ignored.
  - flush clears all busy bits at the next edge and takes priority over busy_set in the same cycle.
  - flush does not cancel a transfer or a pending rf_en.
- A transfer to a register whose busy bit is 0 is legal; the write still happens and busy stays 0.

Decomposition:
- Shared package rf_pkg:
  - XLEN, AW and NREGS=2**AW constants.
  - typedef rf_addr_t (logic [AW-1:0]) and rf_data_t (logic [XLEN-1:0]).
  - typedef rf_wr_t struct {en, wa, wd}, used for the write-port bundle.
- One sub-module, rr_arbiter: NREQ-wide round-robin grant with pointer update.
  - Inputs: clk, rst_n, req, advance.
  - Output: grant (one-hot).
  - Reusable for other shared resources.
- Scoreboard and output registers stay in the top level.

Test Plan:
- Single request: req_valid=3'b001, wa=5, wd=32'hDEADBEEF → req_ready=3'b001 same cycle. Next cycle rf_en=1, rf_wa=5, rf_wd=32'hDEADBEEF. Following cycle rf_en=0.
- Contention and fairness: all three valid for 6 cycles after reset, distinct wa 1/2/3 → grant order 0,1,2,0,1,2. rf_en high 6 consecutive cycles, each one cycle after its grant.
- x0 write: requester 1 valid with wa=0, wd=32'h1234 → ready=1, rr_ptr advances to 2, rf_en stays 0.
- Scoreboard:
  - busy_set addr=7 → busy[7]=1 next cycle.
  - Later transfer wa=7 → busy[7]=0 at the same edge rf_en=1.
  - busy_set addr=7 in the same cycle as a transfer wa=7 → busy[7] remains 1.
- Flush and x0:
  - Set busy for 3 and 9, then flush together with busy_set addr=4 → busy all zero next cycle.
  - busy_set addr=0 → busy[0] stays 0.
- Reset mid-operation: assert rst_n=0 asynchronously during a transfer cycle (between edges) → rf_en=0 and busy=0 immediately. After release, first grant goes to requester 0 regardless of prior pointer.
